// File: rtl/soc_ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: port indices and grant-state encoding.
package soc_ram_arb_pkg;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Grant state: which port (if any) was granted in the previous cycle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } gnt_state_e;

endpackage

// File: rtl/soc_ram_arb_pick.sv
// Combinational winner selection between the two eligible ports.
// SOC_RAM_ARB_RR_EN selects round-robin tie-breaking; otherwise the data port always wins ties.
module soc_ram_arb_pick
  import soc_ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_port,
  output logic [1:0] grant
);

`ifndef SOC_RAM_ARB_RR_EN
  // Fixed priority ignores the previous winner.
  logic unused_last_port;
  assign unused_last_port = last_port;
`endif

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01: grant[PORT_INSTR] = 1'b1;
      2'b10: grant[PORT_DATA]  = 1'b1;
      2'b11: begin
`ifdef SOC_RAM_ARB_RR_EN
        if (last_port == PORT_INSTR) begin
          grant[PORT_DATA] = 1'b1;
        end else begin
          grant[PORT_INSTR] = 1'b1;
        end
`else
        grant[PORT_DATA] = 1'b1;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/soc_ram_arbiter.sv
// Two-master arbiter in front of the on-chip RAM: instruction port 0, data port 1.
// Tie-break policy is selected by SOC_RAM_ARB_RR_EN (see soc_ram_arb_pick).
module soc_ram_arbiter
  import soc_ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [WORD_WIDTH-1:0] p0_mask_i,
  input  logic [WORD_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_ack_o,
  output logic [WORD_WIDTH-1:0] p0_rdata_o,

  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [WORD_WIDTH-1:0] p1_mask_i,
  input  logic [WORD_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_ack_o,
  output logic [WORD_WIDTH-1:0] p1_rdata_o,

  output logic                  ram_sel_o,
  output logic                  ram_read_o,
  output logic                  ram_write_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [WORD_WIDTH-1:0] ram_mask_o,
  output logic [WORD_WIDTH-1:0] ram_data_o,
  input  logic [WORD_WIDTH-1:0] ram_data_i
);

  gnt_state_e state_q, state_d;
  logic       gnt_rd_q, gnt_rd_d;
  logic       last_port_q, last_port_d;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       sel_we;

  // A port granted last cycle is still holding its request until it sees the ack.
  assign eligible[PORT_INSTR] = p0_req_i && (state_q != StBusy0);
  assign eligible[PORT_DATA]  = p1_req_i && (state_q != StBusy1);

  soc_ram_arb_pick u_pick (
    .eligible  (eligible),
    .last_port (last_port_q),
    .grant     (grant)
  );

  always_comb begin
    ram_sel_o   = 1'b0;
    ram_read_o  = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_mask_o  = '1;
    ram_data_o  = '0;
    sel_we      = 1'b0;
    state_d     = StIdle;
    gnt_rd_d    = 1'b0;
    last_port_d = last_port_q;

    if (grant[PORT_DATA]) begin
      sel_we      = p1_we_i;
      ram_addr_o  = p1_addr_i;
      ram_mask_o  = p1_mask_i;
      ram_data_o  = p1_wdata_i;
      state_d     = StBusy1;
      last_port_d = PORT_DATA;
    end else if (grant[PORT_INSTR]) begin
      sel_we      = p0_we_i;
      ram_addr_o  = p0_addr_i;
      ram_mask_o  = p0_mask_i;
      ram_data_o  = p0_wdata_i;
      state_d     = StBusy0;
      last_port_d = PORT_INSTR;
    end

    if (|grant) begin
      ram_sel_o   = 1'b1;
      ram_read_o  = !sel_we;
      ram_write_o = sel_we;
      gnt_rd_d    = !sel_we;
    end
  end

  always_comb begin
    p0_ack_o   = (state_q == StBusy0);
    p1_ack_o   = (state_q == StBusy1);
    p0_rdata_o = (p0_ack_o && gnt_rd_q) ? ram_data_i : '0;
    p1_rdata_o = (p1_ack_o && gnt_rd_q) ? ram_data_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      gnt_rd_q    <= 1'b0;
      last_port_q <= PORT_DATA;
    end else begin
      state_q     <= state_d;
      gnt_rd_q    <= gnt_rd_d;
      last_port_q <= last_port_d;
    end
  end

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Self-checking bench for soc_ram_arbiter: directed scenarios plus random two-master traffic.
module tb_soc_ram_arbiter;

  localparam int AW = 9;
  localparam int WW = 16;
`ifdef SOC_RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [WW-1:0] mask;
    logic [WW-1:0] wdata;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [WW-1:0] p0_mask_i, p0_wdata_i, p1_mask_i, p1_wdata_i;
  logic          p0_ack_o, p1_ack_o;
  logic [WW-1:0] p0_rdata_o, p1_rdata_o;
  logic          ram_sel_o, ram_read_o, ram_write_o;
  logic [AW-1:0] ram_addr_o;
  logic [WW-1:0] ram_mask_o, ram_data_o;
  logic [WW-1:0] ram_data_i;

  always #5 clk = ~clk;

  soc_ram_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .p0_req_i    (p0_req_i),
    .p0_we_i     (p0_we_i),
    .p0_addr_i   (p0_addr_i),
    .p0_mask_i   (p0_mask_i),
    .p0_wdata_i  (p0_wdata_i),
    .p0_ack_o    (p0_ack_o),
    .p0_rdata_o  (p0_rdata_o),
    .p1_req_i    (p1_req_i),
    .p1_we_i     (p1_we_i),
    .p1_addr_i   (p1_addr_i),
    .p1_mask_i   (p1_mask_i),
    .p1_wdata_i  (p1_wdata_i),
    .p1_ack_o    (p1_ack_o),
    .p1_rdata_o  (p1_rdata_o),
    .ram_sel_o   (ram_sel_o),
    .ram_read_o  (ram_read_o),
    .ram_write_o (ram_write_o),
    .ram_addr_o  (ram_addr_o),
    .ram_mask_o  (ram_mask_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i)
  );

  // RAM macro stand-in: masked write, one-cycle registered read.
  logic [WW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_sel_o && ram_write_o)
      ram[ram_addr_o] <= (ram[ram_addr_o] & ram_mask_o) | (ram_data_o & ~ram_mask_o);
    if (ram_sel_o && ram_read_o)
      ram_data_i <= ram[ram_addr_o];
  end

  // Reference model state.
  logic [WW-1:0] ref_mem [0:(1<<AW)-1];
  op_t           q0[$];
  op_t           q1[$];
  op_t           cur [2];
  bit            busy [2];
  bit            acked [2];
  int            rate [2];
  int            prev_g = -1;
  int            last_w = 1;
  bit            pend_rd;
  logic [WW-1:0] pend_val;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.we    = 1'($urandom_range(0, 1));
    o.addr  = AW'($urandom_range(0, 15));
    o.mask  = WW'($urandom);
    o.wdata = WW'($urandom);
    return o;
  endfunction

  function automatic op_t mk_op(input logic we, input int addr, input int mask, input int wdata);
    op_t o;
    o.we    = we;
    o.addr  = AW'(addr);
    o.mask  = WW'(mask);
    o.wdata = WW'(wdata);
    return o;
  endfunction

  // One clock cycle: present requests, check RAM side and responses, advance the model.
  task automatic step(input bit do_rst);
    int            g;
    bit            e0, e1;
    op_t           w;
    logic [WW-1:0] all_ones;
    all_ones = '1;
    for (int p = 0; p < 2; p++) begin
      if (acked[p]) busy[p] = 1'b0;
      acked[p] = 1'b0;
      if (!busy[p]) begin
        if (p == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front();
          busy[0] = 1'b1;
        end else if (p == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front();
          busy[1] = 1'b1;
        end else if ($urandom_range(0, 99) < rate[p]) begin
          cur[p] = rand_op();
          busy[p] = 1'b1;
        end else begin
          cur[p] = rand_op();
        end
      end
    end
    p0_req_i = busy[0]; p0_we_i = cur[0].we; p0_addr_i = cur[0].addr;
    p0_mask_i = cur[0].mask; p0_wdata_i = cur[0].wdata;
    p1_req_i = busy[1]; p1_we_i = cur[1].we; p1_addr_i = cur[1].addr;
    p1_mask_i = cur[1].mask; p1_wdata_i = cur[1].wdata;
    rst_i = do_rst;
    #2;

    e0 = busy[0] && prev_g != 0;
    e1 = busy[1] && prev_g != 1;
    if (e0 && e1) g = RR ? 1 - last_w : 1;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;

    check("ram_sel", ram_sel_o, g >= 0);
    if (g >= 0) begin
      w = cur[g];
      check("ram_read", ram_read_o, !w.we);
      check("ram_write", ram_write_o, w.we);
      check("ram_addr", ram_addr_o, w.addr);
      check("ram_mask", ram_mask_o, w.mask);
      check("ram_data", ram_data_o, w.wdata);
    end else begin
      check("idle_read", ram_read_o, 0);
      check("idle_write", ram_write_o, 0);
      check("idle_addr", ram_addr_o, 0);
      check("idle_mask", ram_mask_o, all_ones);
      check("idle_data", ram_data_o, 0);
    end

    check("p0_ack", p0_ack_o, prev_g == 0);
    check("p1_ack", p1_ack_o, prev_g == 1);
    check("p0_rdata", p0_rdata_o, (prev_g == 0 && pend_rd) ? pend_val : '0);
    check("p1_rdata", p1_rdata_o, (prev_g == 1 && pend_rd) ? pend_val : '0);
    if (prev_g >= 0) acked[prev_g] = 1'b1;

    if (g >= 0) begin
      if (w.we) ref_mem[w.addr] = (ref_mem[w.addr] & w.mask) | (w.wdata & ~w.mask);
      else      pend_val = ref_mem[w.addr];
      pend_rd = !w.we;
      last_w  = g;
    end
    prev_g = g;
    if (do_rst) begin
      // Reset drops the in-flight ack; masters abandon and reissue later.
      prev_g = -1;
      last_w = 1;
      for (int p = 0; p < 2; p++) begin
        busy[p]  = 1'b0;
        acked[p] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WW-1:0] v;
    logic [WW-1:0] all_ones;
    all_ones = '1;
    for (int i = 0; i < (1 << AW); i++) begin
      v = WW'($urandom);
      if (i == 'h010) v = 16'h1234;
      if (i == 'h020) v = 16'h5555;
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram_data_i <= '0;
    for (int p = 0; p < 2; p++) begin
      busy[p] = 1'b0; acked[p] = 1'b0; rate[p] = 0; cur[p] = rand_op();
    end
    rst_i = 1'b1;
    p0_req_i = 1'b0; p0_we_i = 1'b0; p0_addr_i = '0; p0_mask_i = '0; p0_wdata_i = '0;
    p1_req_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = '0; p1_mask_i = '0; p1_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p0_ack", p0_ack_o, 0);
    check("rst_p1_ack", p1_ack_o, 0);
    check("rst_p0_rdata", p0_rdata_o, 0);
    check("rst_p1_rdata", p1_rdata_o, 0);
    check("rst_ram_sel", ram_sel_o, 0);
    check("rst_ram_mask", ram_mask_o, all_ones);

    // Single read of a preset word.
    q0.push_back(mk_op(1'b0, 'h010, 0, 0));
    repeat (3) step(1'b0);

    // Masked write then read back on the data port.
    q1.push_back(mk_op(1'b1, 'h020, 'hFF00, 'hABCD));
    q1.push_back(mk_op(1'b0, 'h020, 0, 0));
    repeat (5) step(1'b0);

    // Both ports with continuous traffic.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk_op(1'b0, i, 0, 0));
      q1.push_back(mk_op(1'(i & 1), 8 + i, 'h0F0F, 'h1111 * (i + 1)));
    end
    repeat (12) step(1'b0);

    // Back-to-back reads from a single master.
    for (int i = 0; i < 8; i++) q0.push_back(mk_op(1'b0, i, 0, 0));
    repeat (20) step(1'b0);

    // Reset in the grant cycle of a p0 read, then reissue.
    q0.push_back(mk_op(1'b0, 'h010, 0, 0));
    step(1'b1);
    step(1'b0);
    q0.push_back(mk_op(1'b0, 'h010, 0, 0));
    repeat (3) step(1'b0);

    // Idle period.
    repeat (10) step(1'b0);

    // Random two-master traffic.
    rate[0] = 60;
    rate[1] = 60;
    repeat (400) step(1'b0);
    rate[0] = 100;
    rate[1] = 100;
    repeat (40) step(1'b0);
    rate[0] = 0;
    rate[1] = 0;
    repeat (4) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soc_ram_arbiter.md
# soc_ram_arbiter

Two-master arbiter placed directly upstream of the on-chip RAM macro wrapper. It accepts independent instruction-fetch (port 0) and data (port 1) request streams from the CPU core and multiplexes them onto the single RAM access port. It tracks the one-cycle registered read latency and returns per-port acknowledge and read data.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: word-address width, identical to the RAM's address width.
- `WORD_WIDTH`, default 16: data and mask width (8, 16 or 32).

Ports (per-port signals are `pN_*` with N = 0, 1):
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `pN_req_i`  in  1  access request; held with stable fields until `pN_ack_o`.
- `pN_we_i`  in  1  1 = write, 0 = read.
- `pN_addr_i`  in  ADDR_WIDTH  word address.
- `pN_mask_i`  in  WORD_WIDTH  write mask; bit = 1 preserves the RAM bit.
- `pN_wdata_i`  in  WORD_WIDTH  write data.
- `pN_ack_o`  out  1  one-cycle completion pulse.
- `pN_rdata_o`  out  WORD_WIDTH  read data; valid only while `pN_ack_o` = 1 for a read; 0 otherwise.
- `ram_sel_o`, `ram_read_o`, `ram_write_o`  out  1  RAM strobes.
- `ram_addr_o`  out  ADDR_WIDTH  RAM address.
- `ram_mask_o`  out  WORD_WIDTH  RAM write mask.
- `ram_data_o`  out  WORD_WIDTH  RAM write data.
- `ram_data_i`  in  WORD_WIDTH  RAM read data, valid one cycle after the read strobe.

## Operation
- Eligibility: port N is eligible in a cycle when `pN_req_i` = 1 and N was not granted in the previous cycle. The previous-grant block prevents re-issuing a request the master has not yet dropped.
- Grant (combinational): exactly one eligible port is granted. With neither eligible, the RAM strobes stay 0.
- RAM drive when port N is granted:
  - `ram_sel_o` = 1.
  - `ram_read_o` = !we.
  - `ram_write_o` = we.
  - addr, mask and data are taken from port N.
- When idle, RAM-side outputs are 0, except that `ram_mask_o` is all ones.
- Registered state:
  - `gnt_vld_q` (grant issued last cycle).
  - `gnt_port_q`.
  - `gnt_rd_q`.
  - `last_port_q` (most recent winner, for priority).
- Response: in the cycle after a grant, `pN_ack_o` = 1 for N = `gnt_port_q`. If `gnt_rd_q` is set, `pN_rdata_o` = `ram_data_i`. The non-selected port's rdata is 0.
- Writes are acknowledged with the same one-cycle latency.
- The grant states behave as follows:
  - IDLE: no grant last cycle.
  - BUSY0: port 0 granted last cycle.
  - BUSY1: port 1 granted last cycle.
  - From any state, the next state follows this cycle's grant, or IDLE when there is none.
- Simultaneous eligible requests are resolved by the Configuration priority rule.
- A master may raise a new request in the cycle after its ack. That request is eligible one cycle later, so single-master throughput is one access per two cycles.
- While both masters are active they alternate, giving one access per cycle in aggregate.

## Timing
- Reset values:
  - All acks 0.
  - All rdata 0.
  - State IDLE.
  - `last_port_q` = 1, so port 0 wins the first tie.
  - RAM strobes 0.
- Latency is request to ack = 1 cycle, provided the request is granted in its first eligible cycle.
- Reset asserted in the grant cycle: the RAM access still occurs (the strobe is already combinational), but the ack the following cycle is suppressed. The master must reissue the request after reset.
- Request deasserted before ack: this is illegal, and the arbiter behaviour is undefined.

## Configuration
- `SOC_RAM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port ≠ `last_port_q` wins.
- `SOC_RAM_ARB_RR_EN` undefined: fixed priority. On a tie, port 1 (data) always wins, and `last_port_q` is not used for arbitration.

## Structure
- Shared package `soc_ram_arb_pkg` holds:
  - port index constants `PORT_INSTR` = 0 and `PORT_DATA` = 1;
  - state encodings IDLE, BUSY0, BUSY1.
- Sub-module `soc_ram_arb_pick`: purely combinational winner selection, with inputs eligible[1:0] and last_port and output grant[1:0] (one-hot or zero). The RR/fixed option is contained entirely inside it.

## Test plan
- Single read: set RAM word 0x010 = 0x1234, then p0 reads addr 0x010 → ram_sel/ram_read pulse in cycle N, `p0_ack_o` in N+1 with rdata 0x1234, and `p1_ack_o` stays 0.
- Masked write then read: p1 writes 0xABCD with mask 0xFF00 over 0x5555 → p1 ack in N+1; a subsequent read returns 0x55CD.
- Both ports requesting continuously:
  - With RR: grants alternate 0,1,0,1 and each port is acked every 2 cycles.
  - Fixed priority: first grant goes to p1, then the grants alternate because of the previous-grant block.
- Single master issuing back-to-back reads to 0..7 → acks every other cycle, data in order, and no duplicate RAM access per request.
- `rst_i` asserted in the grant cycle of a p0 read → no ack the next cycle, all outputs 0, and the reissued request completes normally.
- Idle: no requests for 10 cycles → ram_sel/read/write remain 0 and `ram_mask_o` is all ones.
